// File: rtl/instr_sequencer.sv
// instr_sequencer: instruction register, decoder and Moore control FSM that
// sequences datapath strobes for one instruction per start pulse, and counts
// retired instructions.
// Optional feature macro: SEQ_ILLEGAL_TRAP_EN (illegal opcode halts the FSM
// and sets a sticky flag; when undefined an illegal opcode retires as a NOP).
module instr_sequencer #(
  parameter int unsigned CNT_W    = 8,
  parameter logic [15:0] IR_RESET = 16'h0000
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             load,
  input  logic             s,
  input  logic [15:0]      in,
  output logic             w,
  output logic [2:0]       readnum,
  output logic [2:0]       writenum,
  output logic             write,
  output logic [1:0]       vsel,
  output logic             loada,
  output logic             loadb,
  output logic             loadc,
  output logic             loads,
  output logic             asel,
  output logic             bsel,
  output logic [1:0]       ALUop,
  output logic [1:0]       shift,
  output logic [15:0]      sximm8,
  output logic [4:0]       imm5,
  output logic [CNT_W-1:0] instr_count,
  output logic             illegal
);

  typedef enum logic [2:0] {
    S_WAIT, S_DECODE, S_WR_IMM, S_GET_A, S_GET_B, S_CALC, S_WR_REG
`ifdef SEQ_ILLEGAL_TRAP_EN
    , S_HALT
`endif
  } state_t;

  state_t             state_q, state_d;
  logic [15:0]        ir_q, ir_d;
  logic [CNT_W-1:0]   cnt_q;
  logic               cnt_inc;

  logic [2:0] opc, rn, rd, rm;
  logic [1:0] op, sh;
  logic       is_movi, is_movr, is_alu, is_cmp, is_mvn, is_legal;

  logic       w_d, write_d, loada_d, loadb_d, loadc_d, loads_d, asel_d, bsel_d;
  logic [2:0] readnum_d, writenum_d;
  logic [1:0] vsel_d, aluop_d, shift_d;

  assign opc = ir_q[15:13];
  assign op  = ir_q[12:11];
  assign rn  = ir_q[10:8];
  assign rd  = ir_q[7:5];
  assign sh  = ir_q[4:3];
  assign rm  = ir_q[2:0];

  assign is_movi  = (opc == 3'b110) && (op == 2'b10);
  assign is_movr  = (opc == 3'b110) && (op == 2'b00);
  assign is_alu   = (opc == 3'b101);
  assign is_cmp   = is_alu && (op == 2'b01);
  assign is_mvn   = is_alu && (op == 2'b11);
  assign is_legal = is_movi || is_movr || is_alu;

  assign sximm8      = {{8{ir_q[7]}}, ir_q[7:0]};
  assign imm5        = ir_q[4:0];
  assign instr_count = cnt_q;

`ifdef SEQ_ILLEGAL_TRAP_EN
  logic ill_q, ill_set;
  assign illegal = ill_q;
`else
  assign illegal = 1'b0;
`endif

  // Next state, IR capture and retirement detection.
  always_comb begin
    state_d = state_q;
    ir_d    = ir_q;
    cnt_inc = 1'b0;
`ifdef SEQ_ILLEGAL_TRAP_EN
    ill_set = 1'b0;
`endif
    case (state_q)
      S_WAIT: begin
        if (load) ir_d = in;
        if (s)    state_d = S_DECODE;
      end
      S_DECODE: begin
        if (is_movi)               state_d = S_WR_IMM;
        else if (is_movr || is_mvn) state_d = S_GET_B;
        else if (is_alu)            state_d = S_GET_A;
        else begin
`ifdef SEQ_ILLEGAL_TRAP_EN
          state_d = S_HALT;
          ill_set = 1'b1;
`else
          state_d = S_WAIT;
          cnt_inc = 1'b1;
`endif
        end
      end
      S_WR_IMM: begin
        state_d = S_WAIT;
        cnt_inc = 1'b1;
      end
      S_GET_A: state_d = S_GET_B;
      S_GET_B: state_d = S_CALC;
      S_CALC: begin
        if (is_cmp) begin
          state_d = S_WAIT;
          cnt_inc = 1'b1;
        end else begin
          state_d = S_WR_REG;
        end
      end
      S_WR_REG: begin
        state_d = S_WAIT;
        cnt_inc = 1'b1;
      end
`ifdef SEQ_ILLEGAL_TRAP_EN
      S_HALT: state_d = S_HALT;
`endif
      default: state_d = S_WAIT;
    endcase
  end

  // Moore outputs for the state being entered. Field decode uses ir_q: the IR
  // only changes on the WAIT->DECODE/WAIT edge, where every strobe is 0.
  always_comb begin
    w_d        = 1'b0;
    readnum_d  = '0;
    writenum_d = '0;
    write_d    = 1'b0;
    vsel_d     = '0;
    loada_d    = 1'b0;
    loadb_d    = 1'b0;
    loadc_d    = 1'b0;
    loads_d    = 1'b0;
    asel_d     = 1'b0;
    bsel_d     = 1'b0;
    aluop_d    = '0;
    shift_d    = '0;
    case (state_d)
      S_WAIT:   w_d = 1'b1;
      S_WR_IMM: begin
        writenum_d = rn;
        vsel_d     = 2'b10;
        write_d    = 1'b1;
      end
      S_GET_A: begin
        readnum_d = rn;
        loada_d   = 1'b1;
      end
      S_GET_B: begin
        readnum_d = rm;
        loadb_d   = 1'b1;
      end
      S_CALC: begin
        shift_d = sh;
        aluop_d = is_movr ? 2'b00 : op;
        asel_d  = is_movr || is_mvn;
        loadc_d = !is_cmp;
        loads_d = is_alu;
      end
      S_WR_REG: begin
        writenum_d = rd;
        write_d    = 1'b1;
      end
      default: ;
    endcase
  end

  // State, IR, counter, sticky flag and registered strobes.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q  <= S_WAIT;
      ir_q     <= IR_RESET;
      cnt_q    <= '0;
      w        <= 1'b1;
      readnum  <= '0;
      writenum <= '0;
      write    <= 1'b0;
      vsel     <= '0;
      loada    <= 1'b0;
      loadb    <= 1'b0;
      loadc    <= 1'b0;
      loads    <= 1'b0;
      asel     <= 1'b0;
      bsel     <= 1'b0;
      ALUop    <= '0;
      shift    <= '0;
`ifdef SEQ_ILLEGAL_TRAP_EN
      ill_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      ir_q     <= ir_d;
      if (cnt_inc) cnt_q <= cnt_q + CNT_W'(1);
      w        <= w_d;
      readnum  <= readnum_d;
      writenum <= writenum_d;
      write    <= write_d;
      vsel     <= vsel_d;
      loada    <= loada_d;
      loadb    <= loadb_d;
      loadc    <= loadc_d;
      loads    <= loads_d;
      asel     <= asel_d;
      bsel     <= bsel_d;
      ALUop    <= aluop_d;
      shift    <= shift_d;
`ifdef SEQ_ILLEGAL_TRAP_EN
      if (ill_set) ill_q <= 1'b1;
`endif
    end
  end

endmodule

// File: tb/tb_instr_sequencer.sv
// Bench for instr_sequencer: directed literal checks plus a randomized run
// compared every cycle against a per-instruction strobe-schedule model.
module tb_instr_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_n, load, s;
  logic [15:0] in;

  logic       w, write, loada, loadb, loadc, loads, asel, bsel, illegal;
  logic [2:0] readnum, writenum;
  logic [1:0] vsel, ALUop, shift;
  logic [15:0] sximm8;
  logic [4:0]  imm5;
  logic [7:0]  instr_count;

  logic       b_w, b_write, b_loada, b_loadb, b_loadc, b_loads, b_asel, b_bsel, b_illegal;
  logic [2:0] b_readnum, b_writenum;
  logic [1:0] b_vsel, b_ALUop, b_shift;
  logic [15:0] b_sximm8;
  logic [4:0]  b_imm5;
  logic [1:0]  b_instr_count;

  instr_sequencer #(.CNT_W(8), .IR_RESET(16'h0000)) dut (
    .clk(clk), .reset_n(reset_n), .load(load), .s(s), .in(in),
    .w(w), .readnum(readnum), .writenum(writenum), .write(write), .vsel(vsel),
    .loada(loada), .loadb(loadb), .loadc(loadc), .loads(loads),
    .asel(asel), .bsel(bsel), .ALUop(ALUop), .shift(shift),
    .sximm8(sximm8), .imm5(imm5), .instr_count(instr_count), .illegal(illegal)
  );

  instr_sequencer #(.CNT_W(2), .IR_RESET(16'h0000)) dut2 (
    .clk(clk), .reset_n(reset_n), .load(load), .s(s), .in(in),
    .w(b_w), .readnum(b_readnum), .writenum(b_writenum), .write(b_write), .vsel(b_vsel),
    .loada(b_loada), .loadb(b_loadb), .loadc(b_loadc), .loads(b_loads),
    .asel(b_asel), .bsel(b_bsel), .ALUop(b_ALUop), .shift(b_shift),
    .sximm8(b_sximm8), .imm5(b_imm5), .instr_count(b_instr_count), .illegal(b_illegal)
  );

  typedef struct packed {
    logic       w;
    logic [2:0] rn;
    logic [2:0] wn;
    logic       wr;
    logic [1:0] vsel;
    logic       la, lb, lc, ls, asel, bsel;
    logic [1:0] alu, sh;
  } ctl_t;

  ctl_t dut_ctl, b_ctl;
  assign dut_ctl = {w, readnum, writenum, write, vsel, loada, loadb, loadc, loads,
                    asel, bsel, ALUop, shift};
  assign b_ctl   = {b_w, b_readnum, b_writenum, b_write, b_vsel, b_loada, b_loadb, b_loadc,
                    b_loads, b_asel, b_bsel, b_ALUop, b_shift};

  int checks = 0;
  int passed = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
  endtask

  // ---------------- behavioural model ----------------
  ctl_t        sched[$];   // strobe pattern of each remaining busy cycle
  logic [15:0] m_ir;
  int unsigned m_cnt;
  bit          m_halt, m_ill, m_pend, m_valid;

  // Schedule of busy cycles for one instruction, straight from the ISA table.
  task automatic plan(input logic [15:0] ir);
    logic [2:0] opc;
    logic [1:0] op;
    bit movi, movr, alu, cmp, mvn;
    ctl_t c;
    opc  = ir[15:13];
    op   = ir[12:11];
    movi = (opc == 3'd6) && (op == 2'd2);
    movr = (opc == 3'd6) && (op == 2'd0);
    alu  = (opc == 3'd5);
    cmp  = alu && (op == 2'd1);
    mvn  = alu && (op == 2'd3);
    c = '0;
    sched.push_back(c);                       // decode cycle
    if (movi) begin
      c = '0; c.wn = ir[10:8]; c.vsel = 2'd2; c.wr = 1'b1;
      sched.push_back(c);
    end else if (movr || alu) begin
      if (!(movr || mvn)) begin
        c = '0; c.rn = ir[10:8]; c.la = 1'b1;
        sched.push_back(c);
      end
      c = '0; c.rn = ir[2:0]; c.lb = 1'b1;
      sched.push_back(c);
      c = '0; c.sh = ir[4:3]; c.alu = movr ? 2'd0 : op; c.asel = movr || mvn;
      c.lc = !cmp; c.ls = alu;
      sched.push_back(c);
      if (!cmp) begin
        c = '0; c.wn = ir[7:5]; c.wr = 1'b1;
        sched.push_back(c);
      end
    end else begin
`ifdef SEQ_ILLEGAL_TRAP_EN
      m_pend = 1'b1;
`endif
    end
  endtask

  always @(posedge clk) begin
    if (!reset_n) begin
      sched.delete();
      m_ir = 16'h0000; m_cnt = 0; m_halt = 0; m_ill = 0; m_pend = 0; m_valid = 1;
    end else if (m_valid && !m_halt) begin
      if (sched.size() > 0) begin
        void'(sched.pop_front());
        if (sched.size() == 0) begin
          if (m_pend) begin m_halt = 1; m_ill = 1; m_pend = 0; end
          else m_cnt++;
        end
      end else begin
        if (load) m_ir = in;
        if (s) plan(m_ir);
      end
    end
  end

  function automatic ctl_t expect_ctl();
    ctl_t c;
    c = '0;
    if (m_halt) return c;
    if (sched.size() > 0) return sched[0];
    c.w = 1'b1;
    return c;
  endfunction

  // Per-cycle comparison of both instances against the model.
  always @(negedge clk) begin
    if (m_valid) begin
      chk("ctl",     32'(dut_ctl), 32'(expect_ctl()));
      chk("ctl_w2",  32'(b_ctl),   32'(expect_ctl()));
      chk("count",   32'(instr_count),   32'(m_cnt[7:0]));
      chk("count_w2",32'(b_instr_count), 32'(m_cnt[1:0]));
      chk("imm",     32'({sximm8, imm5}), 32'({{8{m_ir[7]}}, m_ir[7:0], m_ir[4:0]}));
      chk("illegal", 32'({illegal, b_illegal}), 32'({m_ill, m_ill}));
    end
  end

  // ---------------- directed helpers ----------------
  task automatic run_instr(input logic [15:0] word, input bit noise,
                           output int busy, output bit saw_wr, output logic [2:0] wn,
                           output bit saw_lc, output bit saw_ls, output bit saw_asel);
    @(negedge clk); in = word; load = 1'b1; s = 1'b1;
    @(negedge clk); load = noise; s = noise; in = noise ? 16'hD1FF : word;
    busy = 0; saw_wr = 0; wn = 3'd0; saw_lc = 0; saw_ls = 0; saw_asel = 0;
    while (w == 1'b0 && busy < 20) begin
      if (write) begin saw_wr = 1; wn = writenum; end
      if (loadc) saw_lc = 1;
      if (loads) saw_ls = 1;
      if (asel)  saw_asel = 1;
      busy++;
      @(negedge clk);
    end
    load = 1'b0; s = 1'b0;
    if (busy >= 20) chk("busy_timeout", 32'(busy), 32'd0);
  endtask

  function automatic logic [15:0] rand_word();
    logic [15:0] r;
    r = 16'($urandom);
    case ($urandom % 5)
      0: r[15:11] = 5'b11010;
      1: r[15:11] = 5'b11000;
      2, 3: r[15:13] = 3'b101;
      default: ;
    endcase
    return r;
  endfunction

  int busy;
  bit saw_wr, saw_lc, saw_ls, saw_asel;
  logic [2:0] wn;

  initial begin
    reset_n = 1'b0; load = 1'b0; s = 1'b0; in = 16'h0000;
    repeat (2) @(negedge clk);
    chk("reset_ctl",   32'(dut_ctl), 32'h80000);
    chk("reset_count", 32'(instr_count), 32'd0);
    chk("reset_ill",   32'(illegal), 32'd0);
    reset_n = 1'b1;

    run_instr(16'hD0FE, 0, busy, saw_wr, wn, saw_lc, saw_ls, saw_asel);
    chk("movi_busy",   32'(busy), 32'd2);
    chk("movi_write",  32'({saw_wr, wn}), 32'({1'b1, 3'd0}));
    chk("movi_sximm8", 32'(sximm8), 32'h0000FFFE);
    chk("movi_count",  32'(instr_count), 32'd1);

    run_instr(16'hA049, 0, busy, saw_wr, wn, saw_lc, saw_ls, saw_asel);
    chk("add_busy",  32'(busy), 32'd5);
    chk("add_write", 32'({saw_wr, wn, saw_lc, saw_ls}), 32'({1'b1, 3'd2, 1'b1, 1'b1}));

    run_instr(16'hAB04, 0, busy, saw_wr, wn, saw_lc, saw_ls, saw_asel);
    chk("cmp_busy",  32'(busy), 32'd4);
    chk("cmp_flags", 32'({saw_wr, saw_lc, saw_ls}), 32'({1'b0, 1'b0, 1'b1}));

    run_instr(16'hB8E7, 1, busy, saw_wr, wn, saw_lc, saw_ls, saw_asel);
    chk("mvn_busy",   32'(busy), 32'd4);
    chk("mvn_write",  32'({saw_wr, wn, saw_asel}), 32'({1'b1, 3'd7, 1'b1}));
    chk("ir_frozen",  32'(sximm8), 32'h0000FFE7);
    chk("count4",     32'(instr_count), 32'd4);
    chk("count4_w2",  32'(b_instr_count), 32'd0);

`ifdef SEQ_ILLEGAL_TRAP_EN
    @(negedge clk); in = 16'hE000; load = 1'b1; s = 1'b1;
    @(negedge clk); load = 1'b0; s = 1'b0;
    repeat (3) @(negedge clk);
    chk("halt_flag", 32'({illegal, w}), 32'({1'b1, 1'b0}));
    reset_n = 1'b0;
    @(negedge clk); reset_n = 1'b1;
    chk("halt_reset", 32'({illegal, w, instr_count}), 32'({1'b0, 1'b1, 8'd0}));
`else
    run_instr(16'hE000, 0, busy, saw_wr, wn, saw_lc, saw_ls, saw_asel);
    chk("nop_busy",  32'({busy[7:0], saw_wr}), 32'({8'd1, 1'b0}));
    chk("nop_count", 32'(instr_count), 32'd5);
`endif

    // Reset landing while the B operand is being fetched.
    @(negedge clk); in = 16'hA049; load = 1'b1; s = 1'b1;
    @(negedge clk); load = 1'b0; s = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("getb_loadb", 32'({loadb, readnum}), 32'({1'b1, 3'd1}));
    reset_n = 1'b0;
    @(negedge clk); reset_n = 1'b1;
    chk("abort", 32'({w, write, instr_count}), 32'({1'b1, 1'b0, 8'd0}));

    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      reset_n = ($urandom_range(0, 79) != 0);
      load    = 1'($urandom % 2);
      s       = (($urandom % 3) == 0);
      in      = rand_word();
    end
    @(negedge clk); load = 1'b0; s = 1'b0;
    @(negedge clk);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
